// File: rtl/_rr_arb8.sv
// 8-way round-robin arbiter feeding one registered n-bit output stage with a valid/ready handshake.
// Optional ARB8_LOCK_EN adds lock[7:0] so a locked winner keeps top priority for burst transfers.
module _rr_arb8 #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   req,
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic [n-1:0] in2,
    input  logic [n-1:0] in3,
    input  logic [n-1:0] in4,
    input  logic [n-1:0] in5,
    input  logic [n-1:0] in6,
    input  logic [n-1:0] in7,
`ifdef ARB8_LOCK_EN
    input  logic [7:0]   lock,
`endif
    output logic [7:0]   gnt,
    output logic [2:0]   sel,
    output logic [n-1:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state, state_nxt;
    logic [2:0]   ptr, ptr_nxt;
    logic [2:0]   winner;
    logic [2:0]   scan_idx;
    logic         found;
    logic         load;
    logic [n-1:0] bank_lo, bank_hi, mux_out;

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            scan_idx = ptr + 3'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    assign load      = (|req) && !rst && (state == IDLE || out_ready);
    assign gnt       = load ? (8'b1 << winner) : '0;
    assign sel       = load ? winner : '0;
    assign out_valid = (state == HOLD);

    always_comb begin
        bank_lo = '0;
        bank_hi = '0;
        case (sel[1:0])
            2'd0: begin bank_lo = in0; bank_hi = in4; end
            2'd1: begin bank_lo = in1; bank_hi = in5; end
            2'd2: begin bank_lo = in2; bank_hi = in6; end
            default: begin bank_lo = in3; bank_hi = in7; end
        endcase
        mux_out = sel[2] ? bank_hi : bank_lo;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (load) begin
            state_nxt = HOLD;
`ifdef ARB8_LOCK_EN
            ptr_nxt   = lock[winner] ? winner : winner + 3'd1;
`else
            ptr_nxt   = winner + 3'd1;
`endif
        end else if (state == HOLD && out_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (load) out <= mux_out;
        end
    end

endmodule

// File: tb/tb__rr_arb8.sv
// Scoreboard bench for _rr_arb8: directed scenarios plus randomized traffic against a behavioural model.
module tb__rr_arb8;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   req = '0;
    logic [N-1:0] din [8];
    logic [7:0]   lock_s = '0;
    logic [7:0]   gnt;
    logic [2:0]   sel;
    logic [N-1:0] out;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] sb [$];

    int mptr   = 0;
    bit mvalid = 0;
    int waits [8];

    always #5 clk = ~clk;

    _rr_arb8 #(.n(N)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
`ifdef ARB8_LOCK_EN
        .lock(lock_s),
`endif
        .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(mptr + k) % 8]) return (mptr + k) % 8;
        return -1;
    endfunction

    // One clock cycle: drive, check comb outputs at negedge, advance model after posedge.
    // exp_w: -2 = no directed expectation, -1 = expect no grant, else expected winner.
    task automatic cycle(input logic [7:0] r, input logic rdy, input logic [7:0] lk,
                         input int exp_w, output int won);
        int  w;
        bit  ld;
        req = r; out_ready = rdy; lock_s = lk;
        @(negedge clk);
        w  = model_winner(r);
        ld = (r != 0) && (!mvalid || rdy);
        check("gnt_model", gnt, ld ? (32'd1 << w) : 32'd0);
        if (ld) check("sel_model", sel, w);
        check("out_valid", out_valid, mvalid);
        if (exp_w != -2) check("gnt_directed", gnt, (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
        if (ld) sb.push_back(din[w]);
        @(posedge clk); #1;
        won = ld ? w : -1;
        if (ld) begin
`ifndef ARB8_LOCK_EN
            for (int i = 0; i < 8; i++) begin
                if (r[i] && i != w) begin
                    waits[i]++;
                    check("fairness", (waits[i] < 8), 1);
                end else waits[i] = 0;
            end
`endif
            mvalid = 1;
            mptr   = lk[w] ? w : (w + 1) % 8;
        end else if (mvalid && rdy) begin
            mvalid = 0;
        end
    endtask

    task automatic do_reset(input logic [7:0] r, input logic rdy);
        req = r; out_ready = rdy; rst = 1'b1;
        @(negedge clk);
        check("gnt_in_reset", gnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        mptr = 0; mvalid = 0;
        foreach (waits[i]) waits[i] = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
    endtask

    // Monitor: checks the presented word against the scoreboard head, pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_empty: out_valid=1 with out=0x%0h but nothing expected", out);
                end else begin
                    check("out_word", out, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int won;
        logic [7:0] pend;
        foreach (din[i]) din[i] = '0;
        foreach (waits[i]) waits[i] = 0;

        // Reset then idle.
        do_reset(8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(8'h00, 1'b0, 8'h00, -1, won);
            check("idle_out", out, 0);
        end

        // All requesting: strict rotation, back-to-back.
        foreach (din[i]) din[i] = N'(i + 'h10);
        for (int k = 0; k < 9; k++) cycle(8'hFF, 1'b1, 8'h00, k % 8, won);
        cycle(8'h00, 1'b1, 8'h00, -1, won);

        // Lone requester 5 wins every cycle.
        for (int k = 0; k < 4; k++) begin
            din[5] = N'($urandom);
            cycle(8'h20, 1'b1, 8'h00, 5, won);
            check("sel_lone5", sel, 5);
        end
        cycle(8'h00, 1'b1, 8'h00, -1, won);

        // Stall: one grant, then none while out_ready=0.
        do_reset(8'h00, 1'b0);
        foreach (din[i]) din[i] = N'($urandom);
        cycle(8'h09, 1'b0, 8'h00, 0, won);
        for (int k = 0; k < 4; k++) cycle(8'h09, 1'b0, 8'h00, -1, won);
        cycle(8'h09, 1'b1, 8'h00, 3, won);
        cycle(8'h00, 1'b1, 8'h00, -1, won);

        // Reset mid-stall discards the held word; ptr restarts at 0 and scan wraps to 7.
        cycle(8'h02, 1'b0, 8'h00, 1, won);
        cycle(8'h02, 1'b0, 8'h00, -1, won);
        do_reset(8'h80, 1'b1);
        cycle(8'h80, 1'b1, 8'h00, 7, won);
        cycle(8'h00, 1'b1, 8'h00, -1, won);

`ifdef ARB8_LOCK_EN
        do_reset(8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cycle(8'h03, 1'b1, 8'h01, 0, won);
        cycle(8'h03, 1'b1, 8'h00, 0, won);
        cycle(8'h03, 1'b1, 8'h00, 1, won);
        cycle(8'h00, 1'b1, 8'h00, -1, won);
`endif

        // Random traffic: requesters hold req and data until granted.
        do_reset(8'h00, 1'b0);
        pend = '0;
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] lk;
            for (int i = 0; i < 8; i++) begin
                if (!pend[i] && ($urandom_range(2) == 0)) begin
                    pend[i] = 1'b1;
                    din[i]  = N'($urandom);
                end
            end
`ifdef ARB8_LOCK_EN
            lk = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
`else
            lk = 8'h00;
`endif
            cycle(pend, ($urandom_range(3) != 0), lk, -2, won);
            if (won >= 0) pend[won] = 1'b0;
            if (k % 701 == 700) begin
                do_reset(pend, 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, 8'h00, -2, won);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/_rr_arb8.md
Name: _rr_arb8

Overview:
- 8-way round-robin arbiter that shares one n-bit transfer path between eight requesters.
- Selects a winner, drives the 3-bit select of an internal 8-input word mux, and captures the selected word into an output register.
- Presents the captured word downstream with a valid/ready handshake.
- Used wherever several CPU units contend for a single write-back or bus path.

Parameters:
n, WORD_LENGTH, width of each data input and of out in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  8  request bit per requester; requester i holds req[i] and in_i stable until it sees gnt[i]
in0..in7  input  n each  requester data words
gnt  output  8  one-hot accept, combinational; gnt[i]=1 in the cycle in_i is captured
sel  output  3  index of current winner, combinational; valid only when |gnt
out  output  n  registered captured word
out_valid  output  1  out holds an untransferred word
out_ready  input  1  downstream accepts out this cycle when out_valid=1

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, out_valid=0, out=0, ptr=0.
  - Requester 0 has highest priority first.
  - rst overrides all other inputs.
  - A word held mid-stall is discarded; no gnt is issued in the reset cycle.
- ptr (3-bit): requester with highest priority.
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … mod 8.
  - Wrap from 7 to 0.
- load = |req && (state==IDLE || out_ready).
- In a load cycle:
  - gnt = onehot(winner), sel = winner.
  - At the clock edge: out<=in_winner, out_valid<=1, ptr<=winner+1 mod 8, state<=HOLD.
- When load=0: gnt=0; sel drives 0 (don't-care).
- IDLE: out_valid=0.
  - |req -> load, go to HOLD.
  - Otherwise remain in IDLE.
- HOLD: out_valid=1.
  - out_ready=0: out held stable, no grant; req changes are ignored.
  - out_ready=1 and |req: word transfers and the next winner loads in the same cycle (back-to-back, one word per cycle).
  - out_ready=1 and no req: word transfers; next cycle out_valid=0, state=IDLE, out keeps its last value.
- out_ready while out_valid=0 is ignored.
- Latency: req in cycle t with an empty output stage -> gnt in cycle t, out_valid=1 in t+1.
- Fairness: any continuously asserted request is granted within 8 load cycles.
- A single requester alone is granted every load cycle.
- Mux select path: sel feeds the internal 8-input mux, built as two 4-input banks plus a final 2:1 stage on sel[2].

Optional Feature:
- ARB8_LOCK_EN defined:
  - Adds input lock [7:0].
  - In a load cycle, if lock[winner]=1, then ptr<=winner instead of winner+1, so the winner keeps top priority for burst transfers.
  - Lock is released by deasserting lock[winner] in a later load cycle, or by dropping req.
- ARB8_LOCK_EN undefined: no lock port; behaviour is exactly as above.

Test Plan:
1. Reset, req=8'h00 for 5 cycles -> out_valid=0, gnt=0, out=0 throughout.
2. req=8'hFF held, in_i=i+0x10, out_ready=1 -> gnt sequence 01,02,04,…,80,01 on consecutive cycles; out=0x10..0x17 then 0x10; out_valid stays 1.
3. Only req[5] held, out_ready=1 -> gnt=8'h20 every cycle, out=in5 each cycle, sel=5.
4. req=8'h09, out_ready=0 after first load -> gnt=8'h01 once; out=in0 held, no gnt for 4 stall cycles; out_ready=1 -> gnt=8'h08, out=in3 next cycle.
5. Stall with out_valid=1, assert rst one cycle -> next cycle out_valid=0, out=0; with req=8'h80, then winner=7 (ptr reset to 0, scan wraps).
6. ARB8_LOCK_EN: req=8'h03, lock=8'h01 for 3 loads then 0 -> gnt 01,01,01,01,02 (the fourth load sees lock=0, advancing ptr to 1).
